demux_stream_nway: RTL and testbench
====================================

Name: demux_stream_nway

Overview:
- Registered, parametrised stream demultiplexer. One WIDTH-bit input stream is routed to one of NUM_OUT output channels, or to all of them in broadcast mode.
- Each channel has a one-entry output register with its own valid/ready handshake.
- It sits between a single producer and several independent consumers. It is the sequential successor to the combinational 4-way 1-bit demux chip.

Parameters:
- WIDTH, 1, data bits per word.
- NUM_OUT, 4, number of output channels (2..16, any integer).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_OUT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  input word.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  1 = deliver word to all channels, in_sel ignored.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- out_data  output  NUM_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  NUM_OUT  channel k register holds a word.
- out_ready  input  NUM_OUT  consumer k takes the word.
- err_sel  output  1  sticky; set when a word with in_sel >= NUM_OUT is accepted in unicast mode.
- drop_cnt  output  8  count of words dropped for bad select; saturates at 255.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 0, err_sel = 0, drop_cnt = 0.
- Channel k is free in a cycle when out_valid[k] = 0 OR out_ready[k] = 1. out_ready is allowed to pass combinationally into in_ready.
- in_ready rules:
  - Unicast, in_sel < NUM_OUT: in_ready = free[in_sel].
  - Broadcast: in_ready = AND of free[k] over all k.
  - Unicast, in_sel >= NUM_OUT: in_ready = 1 (word is dropped).
- Accept = in_valid & in_ready, sampled at the rising clk edge.
- Accept, unicast, valid select: out_data[sel] <= in_data and out_valid[sel] <= 1 at that edge. Latency is 1 cycle: the word is visible the cycle after acceptance.
- Accept, broadcast: every channel loads in_data and sets out_valid. Broadcast is all-or-nothing; a partial broadcast never occurs.
- Accept, bad select: no channel changes; err_sel <= 1; drop_cnt increments unless it is already 255.
- A channel with out_valid & out_ready and no new load clears out_valid at the edge. out_data holds its last value.
- Simultaneous drain and load on the same channel: the new word is loaded and out_valid stays 1. This sustains full throughput of 1 word/cycle per channel.
- A stalled channel (out_valid = 1, out_ready = 0):
  - out_data and out_valid are held stable until taken.
  - Unicast words for other channels still flow (no head-of-line blocking except on the selected channel).
- While in_valid = 1 and in_ready = 0, the producer must hold in_data, in_sel and in_bcast stable. The block does not register a stalled request.
- in_valid = 0: no state change except drains.
- Reset asserted mid-transfer: all held words are discarded immediately. After release, the first accepted word behaves as from a clean reset.
- err_sel clears only on reset.
- The block is fully synchronous apart from reset. It contains no combinational path from in_data to out_data.

Test Plan:
- Reset, then NUM_OUT=4, WIDTH=8, all out_ready = 1. Send 0xA1 to sel 0, 0xB2 to sel 1, 0xC3 to sel 2 and 0xD4 to sel 3 on consecutive cycles -> each out_valid pulses one cycle after its accept with the matching data; in_ready stays 1 throughout.
- out_ready[2] = 0. Send 0x11 to sel 2, then 0x22 to sel 2, then 0x33 to sel 0 -> 0x11 is held on channel 2 and in_ready is 0 for the second word. Under that stall, put 0x33/sel 0 on the input: it is accepted and channel 0 delivers it. Raise out_ready[2] -> 0x22 is accepted in the same cycle (drain plus load) and appears next cycle.
- Broadcast 0x5A with out_ready[1] = 0 and channel 1 full -> in_ready = 0 and no channel loads. Release out_ready[1] -> all four channels show 0x5A the next cycle.
- NUM_OUT=3, SEL_W=2, send sel=3 three times -> in_ready = 1, no out_valid asserts, err_sel = 1 after the first, drop_cnt = 3.
- Send 260 bad-select words -> drop_cnt saturates at 255.
- With channels 0 and 3 full, assert rst_n low mid-cycle (asynchronous) -> out_valid = 0, drop_cnt = 0 and err_sel = 0 immediately. Release, send 0x7E to sel 3 -> it is delivered normally one cycle later.

Source files
------------

// File: rtl/demux_stream_nway_if.sv
// Stream demux bundle: one producer-side request stream plus NUM_OUT
// consumer channels, with the select-error status that travels with them.
interface demux_stream_nway_if #(
  parameter int WIDTH   = 1,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2
);
  logic [WIDTH-1:0]         in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_bcast;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_OUT*WIDTH-1:0] out_data;
  logic [NUM_OUT-1:0]       out_valid;
  logic [NUM_OUT-1:0]       out_ready;
  logic                     err_sel;
  logic [7:0]               drop_cnt;

  // Environment side: producer plus all consumers.
  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err_sel, drop_cnt
  );

  // Demux side.
  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid, err_sel, drop_cnt
  );
endinterface

// File: rtl/demux_stream_nway.sv
// Registered 1-to-NUM_OUT stream demultiplexer with broadcast. Each channel
// owns a one-entry output register; a word is accepted only when every
// channel it targets can take it in the same edge, so broadcast is
// all-or-nothing. Unicast words with an out-of-range select are swallowed
// and counted.
module demux_stream_nway #(
  parameter int WIDTH   = 1,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2
) (
  input logic                clk,
  input logic                rst_n,
  demux_stream_nway_if.slave stream
);

  localparam logic [SEL_W:0] NUM_OUT_C = (SEL_W+1)'(NUM_OUT);

  logic [NUM_OUT*WIDTH-1:0] data_p0;
  logic [NUM_OUT-1:0]       valid_p0;
  logic                     err_p0;
  logic [7:0]               cnt_p0;

  logic [NUM_OUT-1:0]       free;
  logic [NUM_OUT-1:0]       load;
  logic                     sel_ok;
  logic                     sel_free;
  logic                     rdy;
  logic                     accept;
  logic                     drop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A channel can take a word if empty or being drained this same edge.
  assign free   = ~valid_p0 | stream.out_ready;
  assign sel_ok = ({1'b0, stream.in_sel} < NUM_OUT_C);

  // Handshake decode: readiness, acceptance and per-channel load strobes.
  always_comb begin
    sel_free = 1'b0;
    load     = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (stream.in_sel == SEL_W'(k)) sel_free = free[k];
    end
    if (stream.in_bcast)  rdy = &free;
    else if (!sel_ok)     rdy = 1'b1;
    else                  rdy = sel_free;
    accept = stream.in_valid & rdy;
    for (int k = 0; k < NUM_OUT; k++) begin
      load[k] = accept & (stream.in_bcast | (stream.in_sel == SEL_W'(k)));
    end
    drop = accept & ~stream.in_bcast & ~sel_ok;
  end

  // ---- stage p0: channel registers ----
  // Valid bits: load wins over drain so a channel sustains one word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_p0 <= '0;
    else        valid_p0 <= load | (valid_p0 & ~stream.out_ready);
  end

  // Channel data: loaded on accept, otherwise held even after it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p0 <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (load[k]) data_p0[k*WIDTH +: WIDTH] <= stream.in_data;
      end
    end
  end

  // Bad-select bookkeeping: sticky flag plus saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_p0 <= 1'b0;
      cnt_p0 <= 8'd0;
    end else if (drop) begin
      err_p0 <= 1'b1;
      cnt_p0 <= sat_inc(cnt_p0);
    end
  end

  assign stream.in_ready  = rdy;
  assign stream.out_data  = data_p0;
  assign stream.out_valid = valid_p0;
  assign stream.err_sel   = err_p0;
  assign stream.drop_cnt  = cnt_p0;

endmodule

// File: tb/tb_demux_stream_nway.sv
// Bench for demux_stream_nway: a 4-way instance with a per-channel
// scoreboard and a 3-way instance for out-of-range select handling.
module tb_demux_stream_nway;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;

  logic [7:0] exp_q[4][$];

  always #5 clk = ~clk;

  demux_stream_nway_if #(.WIDTH(8), .NUM_OUT(4), .SEL_W(2)) b4 ();
  demux_stream_nway_if #(.WIDTH(8), .NUM_OUT(3), .SEL_W(2)) b3 ();

  demux_stream_nway #(.WIDTH(8), .NUM_OUT(4), .SEL_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .stream(b4.slave)
  );
  demux_stream_nway #(.WIDTH(8), .NUM_OUT(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .stream(b3.slave)
  );

  // Mid-cycle view of the coming edge: drains pop, accepts push.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (b4.out_valid[k] && b4.out_ready[k]) begin
          n_vec++;
          if (exp_q[k].size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected ch%0d got %h want nothing", k, b4.out_data[k*8 +: 8]);
          end else begin
            if (b4.out_data[k*8 +: 8] !== exp_q[k][0]) begin
              n_fail++;
              $display("FAIL sb_data ch%0d got %h want %h", k, b4.out_data[k*8 +: 8], exp_q[k][0]);
            end
            void'(exp_q[k].pop_front());
          end
        end
      end
      if (b4.in_valid && b4.in_ready) begin
        if (b4.in_bcast) begin
          for (int k = 0; k < 4; k++) exp_q[k].push_back(b4.in_data);
        end else begin
          exp_q[b4.in_sel].push_back(b4.in_data);
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic [7:0] d, input logic [1:0] s, input logic bc, input logic v);
    b4.in_data  = d;
    b4.in_sel   = s;
    b4.in_bcast = bc;
    b4.in_valid = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_vec++;
    if (b4.out_valid !== 4'b0000 || b4.out_data !== 32'h0 || b3.out_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs got v4=%b d4=%h v3=%b want 0", b4.out_valid, b4.out_data, b3.out_valid);
    end
    n_vec++;
    if (b3.err_sel !== 1'b0 || b3.drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_status got err=%b drop=%0d want 0/0", b3.err_sel, b3.drop_cnt);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_unicast();
    logic [7:0] words [4];
    logic [3:0] expv;
    words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    b4.out_ready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      next();
      if (i < 4) drive4(words[i], 2'(i), 1'b0, 1'b1);
      else       b4.in_valid = 1'b0;
      @(negedge clk);
      if (i < 4) begin
        n_vec++;
        if (b4.in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL unicast_ready i=%0d got %b want 1", i, b4.in_ready);
        end
      end
      if (i > 0) begin
        expv = 4'(1 << (i - 1));
        n_vec++;
        if (b4.out_valid !== expv) begin
          n_fail++;
          $display("FAIL unicast_valid i=%0d got %b want %b", i, b4.out_valid, expv);
        end
      end
    end
    next();
    @(negedge clk);
    n_vec++;
    if (b4.out_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL unicast_idle got %b want 0000", b4.out_valid);
    end
  endtask

  task automatic test_stall();
    b4.out_ready = 4'b1011;
    next(); drive4(8'h11, 2'd2, 1'b0, 1'b1);
    @(negedge clk);
    n_vec++;
    if (b4.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_first_ready got %b want 1", b4.in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      next(); drive4(8'h22, 2'd2, 1'b0, 1'b1);
      @(negedge clk);
      n_vec++;
      if (b4.in_ready !== 1'b0 || b4.out_valid[2] !== 1'b1 || b4.out_data[23:16] !== 8'h11) begin
        n_fail++;
        $display("FAIL stall_hold i=%0d got rdy=%b v2=%b d2=%h want 0/1/11", i, b4.in_ready, b4.out_valid[2], b4.out_data[23:16]);
      end
    end
    next(); drive4(8'h33, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    n_vec++;
    if (b4.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_bypass_ready got %b want 1", b4.in_ready);
    end
    next(); drive4(8'h22, 2'd2, 1'b0, 1'b1);
    @(negedge clk);
    n_vec++;
    if (b4.in_ready !== 1'b0 || b4.out_valid !== 4'b0101 || b4.out_data[7:0] !== 8'h33) begin
      n_fail++;
      $display("FAIL stall_bypass got rdy=%b v=%b d0=%h want 0/0101/33", b4.in_ready, b4.out_valid, b4.out_data[7:0]);
    end
    next(); b4.out_ready = 4'hF;
    @(negedge clk);
    n_vec++;
    if (b4.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_drain_load_ready got %b want 1", b4.in_ready);
    end
    next(); b4.in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (b4.out_valid !== 4'b0100 || b4.out_data[23:16] !== 8'h22) begin
      n_fail++;
      $display("FAIL stall_reload got v=%b d2=%h want 0100/22", b4.out_valid, b4.out_data[23:16]);
    end
    next();
    @(negedge clk);
    n_vec++;
    if (b4.out_valid !== 4'b0000) begin
      n_fail++; $display("FAIL stall_idle got %b want 0000", b4.out_valid);
    end
  endtask

  task automatic test_broadcast();
    b4.out_ready = 4'b1101;
    next(); drive4(8'h44, 2'd1, 1'b0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      next(); drive4(8'h5A, 2'd0, 1'b1, 1'b1);
      @(negedge clk);
      n_vec++;
      if (b4.in_ready !== 1'b0 || b4.out_valid !== 4'b0010) begin
        n_fail++;
        $display("FAIL bcast_blocked i=%0d got rdy=%b v=%b want 0/0010", i, b4.in_ready, b4.out_valid);
      end
    end
    next(); b4.out_ready = 4'hF;
    @(negedge clk);
    n_vec++;
    if (b4.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bcast_ready got %b want 1", b4.in_ready);
    end
    next(); drive4(8'h00, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++;
    if (b4.out_valid !== 4'b1111 || b4.out_data !== 32'h5A5A5A5A) begin
      n_fail++;
      $display("FAIL bcast_all got v=%b d=%h want 1111/5a5a5a5a", b4.out_valid, b4.out_data);
    end
    next();
    @(negedge clk);
    n_vec++;
    if (b4.out_valid !== 4'b0000) begin
      n_fail++; $display("FAIL bcast_idle got %b want 0000", b4.out_valid);
    end
  endtask

  task automatic test_bad_select();
    int chunk [3];
    int want  [3];
    chunk = '{251, 1, 8};
    want  = '{254, 255, 255};
    b3.out_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      next();
      b3.in_data = 8'(8'hE0 + i); b3.in_sel = 2'd3; b3.in_bcast = 1'b0; b3.in_valid = 1'b1;
      @(negedge clk);
      n_vec++;
      if (b3.in_ready !== 1'b1 || b3.err_sel !== (i > 0)) begin
        n_fail++;
        $display("FAIL badsel_ready i=%0d got rdy=%b err=%b want 1/%0d", i, b3.in_ready, b3.err_sel, (i > 0));
      end
    end
    next(); b3.in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (b3.err_sel !== 1'b1 || b3.drop_cnt !== 8'd3 || b3.out_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL badsel_count got err=%b drop=%0d v=%b want 1/3/000", b3.err_sel, b3.drop_cnt, b3.out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < chunk[c]; i++) begin
        next(); b3.in_valid = 1'b1;
      end
      next(); b3.in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (b3.drop_cnt !== 8'(want[c]) || b3.out_valid !== 3'b000) begin
        n_fail++;
        $display("FAIL badsel_sat c=%0d got drop=%0d v=%b want %0d/000", c, b3.drop_cnt, b3.out_valid, want[c]);
      end
    end
  endtask

  task automatic test_async_reset();
    b4.out_ready = 4'b0110;
    next(); drive4(8'h01, 2'd0, 1'b0, 1'b1);
    next(); drive4(8'h02, 2'd3, 1'b0, 1'b1);
    next(); b4.in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (b4.out_valid !== 4'b1001) begin
      n_fail++; $display("FAIL areset_fill got %b want 1001", b4.out_valid);
    end
    next();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (b4.out_valid !== 4'b0000 || b4.out_data !== 32'h0 || b3.drop_cnt !== 8'd0 || b3.err_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_clear got v=%b d=%h drop=%0d err=%b want 0", b4.out_valid, b4.out_data, b3.drop_cnt, b3.err_sel);
    end
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    b4.out_ready = 4'hF;
    next(); drive4(8'h7E, 2'd3, 1'b0, 1'b1);
    @(negedge clk);
    n_vec++;
    if (b4.in_ready !== 1'b1 || b4.out_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL areset_first_ready got rdy=%b v=%b want 1/0000", b4.in_ready, b4.out_valid);
    end
    next(); b4.in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (b4.out_valid !== 4'b1000 || b4.out_data[31:24] !== 8'h7E) begin
      n_fail++;
      $display("FAIL areset_first_word got v=%b d3=%h want 1000/7e", b4.out_valid, b4.out_data[31:24]);
    end
    next();
  endtask

  initial begin
    drive4(8'h00, 2'd0, 1'b0, 1'b0);
    b4.out_ready = 4'h0;
    b3.in_data = 8'h00; b3.in_sel = 2'd0; b3.in_bcast = 1'b0; b3.in_valid = 1'b0;
    b3.out_ready = 3'b000;
    test_reset();
    test_unicast();
    test_stall();
    test_broadcast();
    test_bad_select();
    test_async_reset();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (exp_q[k].size() != 0) begin
        n_fail++;
        $display("FAIL sb_leftover ch%0d got %0d pending want 0", k, exp_q[k].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
